// File: rtl/parc_core_dpath_wb_arb.sv
// rtl/parc_core_dpath_wb_arb.sv - regfile write-port arbiter and long-op scoreboard
module parc_core_dpath_wb_arb #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        long_issue_val,
    input  logic [4:0]  long_issue_waddr,
    output logic        long_issue_rdy,
    input  logic        long_resp_val,
    input  logic [4:0]  long_resp_waddr,
    input  logic [31:0] long_resp_wdata,
    output logic        long_resp_rdy,
    input  logic [4:0]  raddr0,
    input  logic [4:0]  raddr1,
    output logic        busy0,
    output logic        busy1,
    output logic        stall_pipe,
    output logic        rf_wen_p,
    output logic [4:0]  rf_waddr_p,
    output logic [31:0] rf_wdata_p
);

    logic [31:0]       pending;
    logic              hold_val;
    logic [4:0]        hold_waddr;
    logic [31:0]       hold_wdata;
    logic [WAIT_W-1:0] wait_cnt;

    logic force_hold;
    logic pipe_win;
    logic drain;
    logic accept;
    logic issue_fire;

    // The held result forces its way in once it has lost MAX_WAIT times.
    assign force_hold = hold_val && (wait_cnt == WAIT_W'(MAX_WAIT));
    assign pipe_win   = pipe_wen && !force_hold;
    assign drain      = hold_val && !pipe_win;
    assign stall_pipe = force_hold && pipe_wen;

    assign long_resp_rdy  = !hold_val || drain;
    assign accept         = long_resp_val && long_resp_rdy;
    assign long_issue_rdy = !pending[long_issue_waddr];
    assign issue_fire     = long_issue_val && long_issue_rdy && (long_issue_waddr != 5'd0);

    assign busy0 = (raddr0 != 5'd0) && pending[raddr0];
    assign busy1 = (raddr1 != 5'd0) && pending[raddr1];

    always_comb begin
        rf_wen_p   = 1'b0;
        rf_waddr_p = 5'd0;
        rf_wdata_p = 32'd0;
        // Reset is asynchronous, so the write port is blocked combinationally too.
        if (reset) begin
            if (pipe_win) begin
                rf_wen_p   = 1'b1;
                rf_waddr_p = pipe_waddr;
                rf_wdata_p = pipe_wdata;
            end else if (hold_val) begin
                rf_wen_p   = 1'b1;
                rf_waddr_p = hold_waddr;
                rf_wdata_p = hold_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= 32'd0;
            hold_val   <= 1'b0;
            hold_waddr <= 5'd0;
            hold_wdata <= 32'd0;
            wait_cnt   <= '0;
        end else begin
            begin : scoreboard
                logic [31:0] pend_next;
                pend_next = pending;
                if (drain)
                    pend_next[hold_waddr] = 1'b0;
                if (issue_fire)
                    pend_next[long_issue_waddr] = 1'b1;
                pending <= pend_next;
            end

            if (accept) begin
                hold_val   <= 1'b1;
                hold_waddr <= long_resp_waddr;
                hold_wdata <= long_resp_wdata;
            end else if (drain) begin
                hold_val <= 1'b0;
            end

            if (drain)
                wait_cnt <= '0;
            else if (hold_val && pipe_win)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_parc_core_dpath_wb_arb.sv
// tb/tb_parc_core_dpath_wb_arb.sv - directed self-checking bench for parc_core_dpath_wb_arb
module tb_parc_core_dpath_wb_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        long_issue_val;
    logic [4:0]  long_issue_waddr;
    logic        long_issue_rdy;
    logic        long_resp_val;
    logic [4:0]  long_resp_waddr;
    logic [31:0] long_resp_wdata;
    logic        long_resp_rdy;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        busy0;
    logic        busy1;
    logic        stall_pipe;
    logic        rf_wen_p;
    logic [4:0]  rf_waddr_p;
    logic [31:0] rf_wdata_p;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    parc_core_dpath_wb_arb #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .pipe_wen(pipe_wen),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .long_issue_val(long_issue_val),
        .long_issue_waddr(long_issue_waddr),
        .long_issue_rdy(long_issue_rdy),
        .long_resp_val(long_resp_val),
        .long_resp_waddr(long_resp_waddr),
        .long_resp_wdata(long_resp_wdata),
        .long_resp_rdy(long_resp_rdy),
        .raddr0(raddr0),
        .raddr1(raddr1),
        .busy0(busy0),
        .busy1(busy1),
        .stall_pipe(stall_pipe),
        .rf_wen_p(rf_wen_p),
        .rf_waddr_p(rf_waddr_p),
        .rf_wdata_p(rf_wdata_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wen         = 1'b0;
        pipe_waddr       = 5'd0;
        pipe_wdata       = 32'd0;
        long_issue_val   = 1'b0;
        long_issue_waddr = 5'd0;
        long_resp_val    = 1'b0;
        long_resp_waddr  = 5'd0;
        long_resp_wdata  = 32'd0;
        raddr0           = 5'd0;
        raddr1           = 5'd0;
    endtask

    task automatic check_rf(input string tag, input logic wen, input logic [4:0] waddr,
                            input logic [31:0] wdata);
        check({tag, "_wen"}, 32'(rf_wen_p), 32'(wen));
        if (wen) begin
            check({tag, "_waddr"}, 32'(rf_waddr_p), 32'(waddr));
            check({tag, "_wdata"}, rf_wdata_p, wdata);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        pipe_wen = 1'b1;
        pipe_waddr = 5'd1;
        pipe_wdata = 32'h1;
        #3;
        check("rst_rf_wen", 32'(rf_wen_p), 32'd0);
        check("rst_stall", 32'(stall_pipe), 32'd0);
        check("rst_resp_rdy", 32'(long_resp_rdy), 32'd1);
        check("rst_issue_rdy", 32'(long_issue_rdy), 32'd1);
        check("rst_busy0", 32'(busy0), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();

        // idle drain
        long_issue_val = 1'b1; long_issue_waddr = 5'd5; raddr0 = 5'd5;
        #3;
        check("drain_issue_rdy", 32'(long_issue_rdy), 32'd1);
        check("drain_busy_pre", 32'(busy0), 32'd0);
        tick();
        long_issue_val = 1'b0;
        long_resp_val = 1'b1; long_resp_waddr = 5'd5; long_resp_wdata = 32'hDEADBEEF;
        #3;
        check("drain_resp_rdy", 32'(long_resp_rdy), 32'd1);
        check("drain_busy_t", 32'(busy0), 32'd1);
        check_rf("drain_t", 1'b0, 5'd0, 32'd0);
        tick();
        long_resp_val = 1'b0;
        #3;
        check_rf("drain_t1", 1'b1, 5'd5, 32'hDEADBEEF);
        check("drain_busy_t1", 32'(busy0), 32'd1);
        tick();
        #3;
        check_rf("drain_t2", 1'b0, 5'd0, 32'd0);
        check("drain_busy_t2", 32'(busy0), 32'd0);
        idle_inputs();
        tick();

        // priority and starvation
        long_resp_val = 1'b1; long_resp_waddr = 5'd7; long_resp_wdata = 32'h11;
        tick();
        long_resp_val = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pipe_wen = 1'b1;
            pipe_waddr = 5'(10 + i);
            pipe_wdata = 32'h100 + 32'(i);
            #3;
            if (i == 4) begin
                check("starve_stall_force", 32'(stall_pipe), 32'd1);
                check_rf("starve_force", 1'b1, 5'd7, 32'h11);
                check("starve_rdy_force", 32'(long_resp_rdy), 32'd1);
            end else begin
                check("starve_stall", 32'(stall_pipe), 32'd0);
                check_rf("starve_pipe", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
            end
            tick();
        end
        idle_inputs();

        // after a forced drain the counter restarts: a new hold loses 4 more times
        long_resp_val = 1'b1; long_resp_waddr = 5'd8; long_resp_wdata = 32'h22;
        tick();
        long_resp_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pipe_wen = 1'b1; pipe_waddr = 5'd20; pipe_wdata = 32'h200;
            #3;
            check("restart_stall", 32'(stall_pipe), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
        tick();

        // back-to-back results
        long_resp_val = 1'b1; long_resp_waddr = 5'd3; long_resp_wdata = 32'd1;
        #3;
        check("b2b_rdy0", 32'(long_resp_rdy), 32'd1);
        tick();
        long_resp_waddr = 5'd4; long_resp_wdata = 32'd2;
        #3;
        check("b2b_rdy1", 32'(long_resp_rdy), 32'd1);
        check_rf("b2b_r3", 1'b1, 5'd3, 32'd1);
        tick();
        long_resp_val = 1'b0;
        #3;
        check_rf("b2b_r4", 1'b1, 5'd4, 32'd2);
        tick();
        #3;
        check_rf("b2b_idle", 1'b0, 5'd0, 32'd0);
        tick();

        // WAW block
        long_issue_val = 1'b1; long_issue_waddr = 5'd9;
        #3;
        check("waw_first", 32'(long_issue_rdy), 32'd1);
        tick();
        #3;
        check("waw_second", 32'(long_issue_rdy), 32'd0);
        tick();
        long_resp_val = 1'b1; long_resp_waddr = 5'd9; long_resp_wdata = 32'h99;
        #3;
        check("waw_resp", 32'(long_issue_rdy), 32'd0);
        tick();
        long_resp_val = 1'b0;
        #3;
        check_rf("waw_drain", 1'b1, 5'd9, 32'h99);
        check("waw_drain_rdy", 32'(long_issue_rdy), 32'd0);
        long_issue_val = 1'b0;
        tick();
        #3;
        check("waw_after", 32'(long_issue_rdy), 32'd1);
        idle_inputs();
        tick();

        // r0 handling
        long_issue_val = 1'b1; long_issue_waddr = 5'd0; raddr0 = 5'd0; raddr1 = 5'd0;
        #3;
        check("r0_issue_rdy", 32'(long_issue_rdy), 32'd1);
        tick();
        long_issue_val = 1'b0;
        long_resp_val = 1'b1; long_resp_waddr = 5'd0; long_resp_wdata = 32'h55;
        #3;
        check("r0_busy0", 32'(busy0), 32'd0);
        check("r0_busy1", 32'(busy1), 32'd0);
        check("r0_rdy_again", 32'(long_issue_rdy), 32'd1);
        tick();
        long_resp_val = 1'b0;
        #3;
        check_rf("r0_drain", 1'b1, 5'd0, 32'h55);
        tick();
        #3;
        check("r0_rdy_after", 32'(long_issue_rdy), 32'd1);
        idle_inputs();
        tick();

        // reset mid-operation with a held result and r5 pending
        long_issue_val = 1'b1; long_issue_waddr = 5'd5;
        tick();
        long_issue_val = 1'b0;
        long_resp_val = 1'b1; long_resp_waddr = 5'd5; long_resp_wdata = 32'hAB;
        pipe_wen = 1'b1; pipe_waddr = 5'd12; pipe_wdata = 32'h12;
        tick();
        long_resp_val = 1'b0; raddr1 = 5'd5;
        #3;
        check("mid_busy_pre", 32'(busy1), 32'd1);
        check("mid_resp_rdy_pre", 32'(long_resp_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_rf_wen", 32'(rf_wen_p), 32'd0);
        check("mid_rst_stall", 32'(stall_pipe), 32'd0);
        check("mid_rst_resp_rdy", 32'(long_resp_rdy), 32'd1);
        check("mid_rst_issue_rdy", 32'(long_issue_rdy), 32'd1);
        check("mid_rst_busy1", 32'(busy1), 32'd0);
        tick();
        reset = 1'b1;
        pipe_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check("post_rst_no_write", 32'(rf_wen_p), 32'd0);
            check("post_rst_busy1", 32'(busy1), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/parc_core_dpath_wb_arb.md
Name: parc_core_dpath_wb_arb

Overview:
- Write-port arbiter and scoreboard for the 5-stage PARC register file's single write port.
- Shares that port between the in-order W-stage writeback and a long-latency unit (mul/div) that returns results out of order through a val/rdy handshake.
- Tracks registers with outstanding long-latency writes so decode can stall on RAW/WAW hazards.
- Sits between the W stage, the long-latency unit and the regfile write inputs (wen_p/waddr_p/wdata_p).

Parameters:
- MAX_WAIT, 4, cycles a held long result may lose arbitration to the pipe before the pipe is forced to yield (1..2^WAIT_W-1).
- WAIT_W, 3, width of the starvation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pipe_wen  in  1  W-stage write request.
- pipe_waddr  in  5  W-stage destination.
- pipe_wdata  in  32  W-stage data.
- long_issue_val  in  1  long op issuing from decode.
- long_issue_waddr  in  5  destination of issuing long op.
- long_issue_rdy  out  1  issue may proceed (destination not already pending).
- long_resp_val  in  1  long unit result valid.
- long_resp_waddr  in  5  result destination.
- long_resp_wdata  in  32  result data.
- long_resp_rdy  out  1  result accepted this cycle when val&&rdy.
- raddr0, raddr1  in  5 each  decode read addresses.
- busy0, busy1  out  1 each  addressed register has a pending long write.
- stall_pipe  out  1  pipe write refused this cycle; W stage must hold and re-present.
- rf_wen_p  out  1  to regfile wen_p.
- rf_waddr_p  out  5  to regfile waddr_p.
- rf_wdata_p  out  32  to regfile wdata_p.

Behaviour:
- State: pending[31:0] scoreboard; hold_val/hold_waddr/hold_wdata (one-entry result buffer); wait_cnt[WAIT_W-1:0].
- Reset (async, any cycle, including mid-transfer): pending=0, hold_val=0, wait_cnt=0. Until the next edge: rf_wen_p=0, stall_pipe=0, busy0/1=0, long_resp_rdy=1, long_issue_rdy=1. A held result is discarded.
- Accept: a long result is taken when long_resp_val && long_resp_rdy, and loads hold next edge, so accept-to-regfile latency is ≥1 cycle.
- long_resp_rdy = !hold_val || drain. Back-to-back accepts occur when the hold register drains in the same cycle.
- Arbitration (combinational; all rf_* outputs are combinational from current state and inputs):
  - force = hold_val && (wait_cnt == MAX_WAIT).
  - stall_pipe = force && pipe_wen.
  - If pipe_wen && !force: pipe wins. rf_* = pipe_*.
  - Else if hold_val: hold drains (drain=1). rf_* = hold_*.
  - Else rf_wen_p=0. rf_waddr_p and rf_wdata_p are don't-care and driven as 0.
- Starvation counter:
  - Increments when hold_val && pipe_wen && !force.
  - Clears to 0 on drain.
  - Holds otherwise. Never exceeds MAX_WAIT.
- Scoreboard:
  - long_issue_rdy = !pending[long_issue_waddr]. This blocks WAW between long ops, with no same-cycle bypass of a clear.
  - Issue fire (val&&rdy) with waddr≠0 sets pending[waddr].
  - Drain clears pending[hold_waddr].
  - Set and clear of different registers in the same cycle both take effect.
- busyN = pending[raddrN]; forced 0 when raddrN==0.
- Writes to r0:
  - An issue to r0 never sets pending and is always ready.
  - A result to r0 still drains (rf_wen_p=1); the regfile discards it.
- A pipe write to a pending register is outside the contract: the write is performed and pending is unchanged.

Test Plan:
- Reset: drive reset=0 mid-operation with hold_val=1 and pending[5]=1 -> all outputs at reset values immediately; after release busy for r5=0 and no write of the held result.
- Idle drain: issue r5, then result r5=0xDEADBEEF with pipe_wen=0 -> accepted at cycle t; cycle t+1 shows rf_wen_p=1, waddr 5, data 0xDEADBEEF; busy on r5 is 1 from issue until after t+1.
- Priority and starvation (MAX_WAIT=4): hold valid (r7=0x11) with pipe_wen=1 for 6 cycles -> pipe writes for 4 cycles; 5th cycle stall_pipe=1 and r7=0x11 written; 6th cycle pipe writes again with wait_cnt=0.
- Back-to-back: results r3=1 then r4=2 on consecutive cycles, pipe idle -> long_resp_rdy stays 1; writes r3 then r4 on consecutive cycles.
- WAW block: issue r9, then issue r9 again before its result -> long_issue_rdy=0 until the r9 drain cycle has passed, then 1.
- r0 handling: issue to r0 -> rdy=1, busy for raddr0=0 stays 0; result to r0 -> rf_wen_p=1, waddr 0, pending unchanged.
